// File: rtl/cordic_pkg.sv
// Shared encodings, FSM states and constant tables for the CORDIC LUT sequencer.
// Table words are IEEE-754 single precision; small angles fall back to exact powers of two.
package cordic_pkg;

    localparam logic MODE_CIRC  = 1'b0;
    localparam logic MODE_HYPER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_t;

    // Hyperbolic iterations that must be executed twice for convergence.
    localparam int REP_IDX_0 = 4;
    localparam int REP_IDX_1 = 13;
    localparam int REP_IDX_2 = 40;

    localparam int TABLE_ATAN  = 0;
    localparam int TABLE_ATANH = 1;

    function automatic logic [31:0] pow2_neg(input int idx);
        return {1'b0, 8'(127 - idx), 23'd0};
    endfunction

    function automatic logic [31:0] atan_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h3F490FDB;
            1:       w = 32'h3EED6338;
            2:       w = 32'h3E7ADBB0;
            3:       w = 32'h3DFEADD5;
            4:       w = 32'h3D7FAADE;
            5:       w = 32'h3CFFEAAE;
            6:       w = 32'h3C7FFAAB;
            7:       w = 32'h3BFFFEAB;
            8:       w = 32'h3B7FFFAB;
            9:       w = 32'h3AFFFFEB;
            10:      w = 32'h3A7FFFFB;
            11:      w = 32'h39FFFFFF;
            default: w = pow2_neg(idx);
        endcase
        return w;
    endfunction

    // Entry 0 is never addressed in hyperbolic mode.
    function automatic logic [31:0] atanh_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h00000000;
            1:       w = 32'h3F0C9F54;
            2:       w = 32'h3E82C577;
            3:       w = 32'h3E00AC47;
            4:       w = 32'h3D802ABC;
            5:       w = 32'h3D000AAD;
            6:       w = 32'h3C8002AB;
            7:       w = 32'h3C0000AB;
            8:       w = 32'h3B80002B;
            9:       w = 32'h3B00000B;
            10:      w = 32'h3A800003;
            11:      w = 32'h3A000001;
            default: w = pow2_neg(idx);
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rom_word(input int table_sel, input int idx);
        return (table_sel == TABLE_ATANH) ? atanh_word(idx) : atan_word(idx);
    endfunction

endpackage

// File: rtl/cordic_lut_sequencer_if.sv
// Beat stream between the CORDIC control FSM, the LUT sequencer and the Z-path.
// slave = sequencer side, master = the controller/consumer side.
interface cordic_lut_sequencer_if #(
    parameter int ROM_WIDTH = 32,
    parameter int ADDR_W    = 5
) ();
    logic                 i_start;
    logic                 i_mode;
    logic                 i_ready;
    logic [ROM_WIDTH-1:0] o_d;
    logic [ADDR_W-1:0]    o_shift;
    logic                 o_valid;
    logic                 o_last;
    logic                 o_busy;
    logic                 o_done;

    modport slave (
        input  i_start, i_mode, i_ready,
        output o_d, o_shift, o_valid, o_last, o_busy, o_done
    );

    modport master (
        output i_start, i_mode, i_ready,
        input  o_d, o_shift, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/cordic_rom_bank.sv
// Synchronous constant ROM with read enable; contents come from the cordic_pkg tables.
// Output register holds its value while the enable is low.
module cordic_rom_bank
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int TABLE_SEL = TABLE_ATAN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WIDTH-1:0]  o_q
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] w_rom [DEPTH];
    logic [WIDTH-1:0] r_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = WIDTH'(rom_word(TABLE_SEL, gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_rom[i_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cordic_lut_sequencer.sv
// Streams atan/atanh constants with their shift amounts, one per accepted beat,
// inserting the hyperbolic repeat iterations automatically.
module cordic_lut_sequencer
    import cordic_pkg::*;
#(
    parameter int ROM_WIDTH = 32,
    parameter int ADDR_W    = 5,
    parameter int N_ITER    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cordic_lut_sequencer_if.slave  bus
);
    localparam int IDX_W = ADDR_W + 1;

    generate
        if (N_ITER < 1 || N_ITER + 1 > 2 ** ADDR_W) begin : g_param_check
            $error("cordic_lut_sequencer: N_ITER out of range for ADDR_W");
        end
    endgenerate

    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] FINAL_CIRC  = IDX_W'(N_ITER - 1);
    localparam logic [IDX_W-1:0] FINAL_HYPER = IDX_W'(N_ITER);
    // Repeat indices beyond N_ITER are disabled so their truncated values never match.
    localparam bit               REP0_EN     = (REP_IDX_0 <= N_ITER);
    localparam bit               REP1_EN     = (REP_IDX_1 <= N_ITER);
    localparam bit               REP2_EN     = (REP_IDX_2 <= N_ITER);
    localparam logic [IDX_W-1:0] REP0        = IDX_W'(REP_IDX_0);
    localparam logic [IDX_W-1:0] REP1        = IDX_W'(REP_IDX_1);
    localparam logic [IDX_W-1:0] REP2        = IDX_W'(REP_IDX_2);
    localparam bit               N_IS_REP    = (N_ITER == REP_IDX_0) || (N_ITER == REP_IDX_1)
                                               || (N_ITER == REP_IDX_2);

    function automatic logic is_repeat(input logic [IDX_W-1:0] idx);
        return (REP0_EN && idx == REP0) || (REP1_EN && idx == REP1) || (REP2_EN && idx == REP2);
    endfunction

    seq_state_t           r_state;
    logic                 r_mode;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_second;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_fire;
    logic                 w_mode_sel;
    logic [IDX_W-1:0]     w_next_idx;
    logic                 w_next_second;
    logic                 w_next_last;
    logic                 w_rom_en;
    logic [ROM_WIDTH-1:0] w_circ_q;
    logic [ROM_WIDTH-1:0] w_hyp_q;

    // Next beat is resolved combinationally so the ROM reads it on the accepting edge.
    always_comb begin
        w_fire        = r_valid & bus.i_ready;
        w_mode_sel    = (r_state == ST_IDLE) ? bus.i_mode : r_mode;
        w_next_idx    = r_idx + IDX_ONE;
        w_next_second = 1'b0;
        if (r_state == ST_IDLE) begin
            w_next_idx = (bus.i_mode == MODE_HYPER) ? IDX_ONE : '0;
        end else if (r_mode == MODE_HYPER && is_repeat(r_idx) && !r_second) begin
            w_next_idx    = r_idx;
            w_next_second = 1'b1;
        end
        if (w_mode_sel == MODE_HYPER) begin
            w_next_last = (w_next_idx == FINAL_HYPER) && (!N_IS_REP || w_next_second);
        end else begin
            w_next_last = (w_next_idx == FINAL_CIRC);
        end
        w_rom_en = ((r_state == ST_IDLE) && bus.i_start)
                 || ((r_state == ST_RUN) && w_fire && !r_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_CIRC;
            r_idx    <= '0;
            r_second <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_mode   <= bus.i_mode;
                        r_idx    <= w_next_idx;
                        r_second <= w_next_second;
                        r_last   <= w_next_last;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_idx    <= w_next_idx;
                            r_second <= w_next_second;
                            r_last   <= w_next_last;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cordic_rom_bank #(
        .WIDTH     (ROM_WIDTH),
        .ADDR_W    (ADDR_W),
        .TABLE_SEL (TABLE_ATAN)
    ) u_rom_circ (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_rom_en),
        .i_addr (w_next_idx[ADDR_W-1:0]),
        .o_q    (w_circ_q)
    );

    cordic_rom_bank #(
        .WIDTH     (ROM_WIDTH),
        .ADDR_W    (ADDR_W),
        .TABLE_SEL (TABLE_ATANH)
    ) u_rom_hyp (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_rom_en),
        .i_addr (w_next_idx[ADDR_W-1:0]),
        .o_q    (w_hyp_q)
    );

    assign bus.o_d     = (r_mode == MODE_HYPER) ? w_hyp_q : w_circ_q;
    assign bus.o_shift = r_idx[ADDR_W-1:0];
    assign bus.o_valid = r_valid;
    assign bus.o_last  = r_last;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_cordic_lut_sequencer.sv
// Directed table-driven bench for cordic_lut_sequencer (N_ITER=16 and N_ITER=13 instances).
module tb_cordic_lut_sequencer;
    import cordic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, ready;
    bit   sel13;

    cordic_lut_sequencer_if #(.ROM_WIDTH(32), .ADDR_W(5)) bus16 ();
    cordic_lut_sequencer_if #(.ROM_WIDTH(32), .ADDR_W(5)) bus13 ();

    cordic_lut_sequencer #(.ROM_WIDTH(32), .ADDR_W(5), .N_ITER(16)) u_dut16 (
        .clk (clk), .rst (rst), .bus (bus16)
    );
    cordic_lut_sequencer #(.ROM_WIDTH(32), .ADDR_W(5), .N_ITER(13)) u_dut13 (
        .clk (clk), .rst (rst), .bus (bus13)
    );

    assign bus16.i_start = start & ~sel13;
    assign bus13.i_start = start & sel13;
    assign bus16.i_mode  = mode;
    assign bus13.i_mode  = mode;
    assign bus16.i_ready = ready;
    assign bus13.i_ready = ready;

    logic [31:0] obs_d;
    logic [4:0]  obs_shift;
    logic        obs_valid, obs_last, obs_busy, obs_done;
    assign obs_d     = sel13 ? bus13.o_d     : bus16.o_d;
    assign obs_shift = sel13 ? bus13.o_shift : bus16.o_shift;
    assign obs_valid = sel13 ? bus13.o_valid : bus16.o_valid;
    assign obs_last  = sel13 ? bus13.o_last  : bus16.o_last;
    assign obs_busy  = sel13 ? bus13.o_busy  : bus16.o_busy;
    assign obs_done  = sel13 ? bus13.o_done  : bus16.o_done;

    int n_run  = 0;
    int n_fail = 0;

    localparam int SEQ_CIRC16 = 0;
    localparam int SEQ_HYP16  = 1;
    localparam int SEQ_HYP13  = 2;

    int seq_circ16 [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int seq_hyp16  [18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
    int seq_hyp13  [15] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

    function automatic int seq_len(input int id);
        return (id == SEQ_CIRC16) ? 16 : (id == SEQ_HYP16) ? 18 : 15;
    endfunction

    function automatic int seq_at(input int id, input int k);
        if (id == SEQ_CIRC16) return seq_circ16[k];
        if (id == SEQ_HYP16)  return seq_hyp16[k];
        return seq_hyp13[k];
    endfunction

    typedef struct {
        bit          use13;
        logic        mode;
        int          seq_id;
        int          stall_shift;
        bit          hold_start;
        bit          flip_mode;
        logic [31:0] od0;
        bit          chk_od1;
        logic [31:0] od1;
        logic [31:0] od_stall;
    } run_t;

    function automatic run_t mk_run(input bit use13, input logic m, input int seq_id,
                                    input int stall_shift, input bit hold_start,
                                    input bit flip_mode, input logic [31:0] od0,
                                    input bit chk_od1, input logic [31:0] od1,
                                    input logic [31:0] od_stall);
        run_t r;
        r.use13 = use13;  r.mode = m;  r.seq_id = seq_id;  r.stall_shift = stall_shift;
        r.hold_start = hold_start;  r.flip_mode = flip_mode;  r.od0 = od0;
        r.chk_od1 = chk_od1;  r.od1 = od1;  r.od_stall = od_stall;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string what, input int rid, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL run%0d %s: actual %h required %h", rid, what, act, exp);
        end
    endtask

    task automatic check_all_zero(input int rid);
        check("rst_d",     rid, obs_d, 32'h0);
        check("rst_shift", rid, 32'(obs_shift), 32'd0);
        check("rst_valid", rid, 32'(obs_valid), 32'd0);
        check("rst_last",  rid, 32'(obs_last),  32'd0);
        check("rst_busy",  rid, 32'(obs_busy),  32'd0);
        check("rst_done",  rid, 32'(obs_done),  32'd0);
    endtask

    task automatic run_one(input int rid, input run_t r);
        int n;
        int done_seen;
        int exp_shift;
        sel13 = r.use13;
        mode  = r.mode;
        ready = 1'b1;
        start = 1'b1;
        step();
        if (!r.hold_start) start = 1'b0;
        n = seq_len(r.seq_id);
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            exp_shift = seq_at(r.seq_id, k);
            check("valid", rid, 32'(obs_valid), 32'd1);
            check("shift", rid, 32'(obs_shift), 32'(exp_shift));
            check("last",  rid, 32'(obs_last), (k == n - 1) ? 32'd1 : 32'd0);
            check("busy",  rid, 32'(obs_busy), 32'd1);
            if (obs_done) done_seen++;
            if (k == 0) check("od_beat0", rid, obs_d, r.od0);
            if (k == 1 && r.chk_od1) check("od_beat1", rid, obs_d, r.od1);
            if (exp_shift == r.stall_shift) begin
                ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check("stall_valid", rid, 32'(obs_valid), 32'd1);
                    check("stall_shift", rid, 32'(obs_shift), 32'(exp_shift));
                    check("stall_od",    rid, obs_d, r.od_stall);
                    if (obs_done) done_seen++;
                end
                ready = 1'b1;
            end
            $display("[TB] run%0d beat %0d shift=%0d od=%h last=%0b", rid, k, obs_shift,
                     obs_d, obs_last);
            if (r.flip_mode) mode = ~mode;
            step();
        end
        check("finish_done",  rid, 32'(obs_done),  32'd1);
        check("finish_valid", rid, 32'(obs_valid), 32'd0);
        check("finish_busy",  rid, 32'(obs_busy),  32'd0);
        if (obs_done) done_seen++;
        start = r.hold_start;
        step();
        check("idle_done",  rid, 32'(obs_done),  32'd0);
        check("idle_valid", rid, 32'(obs_valid), 32'd0);
        start = 1'b0;
        step();
        check("no_restart_valid", rid, 32'(obs_valid), 32'd0);
        check("no_restart_busy",  rid, 32'(obs_busy),  32'd0);
        if (obs_done) done_seen++;
        check("done_count", rid, 32'(done_seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    run_t runs [6];
    int   guard;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = MODE_CIRC;
        ready = 1'b0;
        sel13 = 1'b0;

        runs[0] = mk_run(0, MODE_CIRC,  SEQ_CIRC16, -1, 0, 0, 32'h3F490FDB, 1, 32'h3EED6338, 32'h0);
        runs[1] = mk_run(0, MODE_HYPER, SEQ_HYP16,  -1, 0, 0, 32'h3F0C9F54, 1, 32'h3E82C577, 32'h0);
        runs[2] = mk_run(0, MODE_CIRC,  SEQ_CIRC16,  6, 0, 0, 32'h3F490FDB, 0, 32'h0, 32'h3C7FFAAB);
        runs[3] = mk_run(0, MODE_HYPER, SEQ_HYP16,   6, 0, 0, 32'h3F0C9F54, 0, 32'h0, 32'h3C8002AB);
        runs[4] = mk_run(0, MODE_CIRC,  SEQ_CIRC16, -1, 1, 1, 32'h3F490FDB, 1, 32'h3EED6338, 32'h0);
        runs[5] = mk_run(1, MODE_HYPER, SEQ_HYP13,  -1, 0, 0, 32'h3F0C9F54, 0, 32'h0, 32'h0);

        repeat (2) step();
        check_all_zero(100);
        sel13 = 1'b1;
        #1;
        check_all_zero(113);
        sel13 = 1'b0;
        rst   = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_one(i, runs[i]);
        end

        // Reset in the middle of a circular run, then restart from the beginning.
        sel13 = 1'b0;
        mode  = MODE_CIRC;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (obs_shift != 5'd9 && guard < 40) begin
            step();
            guard++;
        end
        check("reach_shift9", 200, 32'(obs_shift), 32'd9);
        $display("[TB] run200 reset asserted at shift=%0d", obs_shift);
        rst = 1'b1;
        step();
        check_all_zero(200);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_done",  200, 32'(obs_done),  32'd0);
            check("post_rst_valid", 200, 32'(obs_valid), 32'd0);
        end
        run_one(6, runs[0]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
